instruction_fetch: RTL and testbench

Fetch stage between the programCounter/mainMemory pair and the instruction decoder of the Ra8 core. It drives the PC load/enable and memory output-enable, reads 1-, 2- or 3-byte instructions byte by byte from the 8-bit data bus, and assembles each into opcode + 16-bit operand. The assembled instruction goes to the decoder over a valid/ready handshake. The block also accepts jump redirects from execute.

---
 rtl/ra8_fetch_pkg.sv | 27 ++
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ra8_fetch_pkg.sv
// Shared definitions for the Ra8 instruction fetch stage: FSM state
// encoding, instruction length codes and the opcode length decode.
package ra8_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } fetch_state_e;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // Instruction length is carried in the two top opcode bits.
  function automatic logic [1:0] instr_len(input logic [7:0] op);
    logic [1:0] len;
    case (op[7:6])
      2'b00:   len = LEN_1;
      2'b01:   len = LEN_2;
      default: len = LEN_3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Ra8 fetch stage: reads 1..3 byte instructions from memory one byte per
// cycle and presents them to the decoder over a valid/ready handshake.
module instruction_fetch
  import ra8_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   memData,
  input  logic [ADDR_WIDTH-1:0]   pc,
  output logic                    pcEnable,
  output logic                    pcLoad,
  output logic [ADDR_WIDTH-1:0]   pcInAddr,
  output logic                    memOutputEnable,
  input  logic                    jumpValid,
  input  logic [ADDR_WIDTH-1:0]   jumpTarget,
  input  logic                    halt,
  output logic                    instrValid,
  input  logic                    instrReady,
  output logic [DATA_WIDTH-1:0]   opcode,
  output logic [2*DATA_WIDTH-1:0] operand,
  output logic [ADDR_WIDTH-1:0]   instrAddr,
  output logic [1:0]              instrLength
);

  // Handshake: the instruction transfers on any rising edge where
  // instrValid and instrReady are both 1; while instrValid=1 and
  // instrReady=0 every instruction output holds its value.

  fetch_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
  logic [2*DATA_WIDTH-1:0] operand_q, operand_d;
  logic [ADDR_WIDTH-1:0]   instr_addr_q, instr_addr_d;
  logic [1:0]              instr_len_q, instr_len_d;
  logic [1:0]              mem_len;

  assign mem_len = instr_len(memData[DATA_WIDTH-1 -: 8]);

  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    operand_d       = operand_q;
    instr_addr_d    = instr_addr_q;
    instr_len_d     = instr_len_q;
    pcEnable        = 1'b0;
    pcLoad          = 1'b0;
    pcInAddr        = '0;
    memOutputEnable = 1'b0;

    if (jumpValid) begin
      // Redirect wins over halt and over any fetch progress.
      pcLoad   = 1'b1;
      pcInAddr = jumpTarget;
      state_d  = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: if (!halt) begin
          memOutputEnable = 1'b1;
          pcEnable        = 1'b1;
          opcode_d        = memData;
          instr_addr_d    = pc;
          instr_len_d     = mem_len;
          operand_d       = '0;
          state_d         = (mem_len == LEN_1) ? HOLD : FETCH_LO;
        end
        FETCH_LO: if (!halt) begin
          memOutputEnable           = 1'b1;
          pcEnable                  = 1'b1;
          operand_d[DATA_WIDTH-1:0] = memData;
          state_d                   = (instr_len_q == LEN_2) ? HOLD : FETCH_HI;
        end
        FETCH_HI: if (!halt) begin
          memOutputEnable                      = 1'b1;
          pcEnable                             = 1'b1;
          operand_d[2*DATA_WIDTH-1:DATA_WIDTH] = memData;
          state_d                              = HOLD;
        end
        HOLD: if (instrReady) state_d = FETCH_OP;
        default: state_d = FETCH_OP;
      endcase
    end

    if (reset) begin
      pcEnable        = 1'b0;
      pcLoad          = 1'b0;
      pcInAddr        = '0;
      memOutputEnable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_OP;
      opcode_q     <= '0;
      operand_q    <= '0;
      instr_addr_q <= '0;
      instr_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      instr_addr_q <= instr_addr_d;
      instr_len_q  <= instr_len_d;
    end
  end

  assign instrValid  = (state_q == HOLD) && !reset;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instrAddr   = instr_addr_q;
  assign instrLength = instr_len_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: models the PC register and memory around the
// DUT and checks emitted instructions against a memory-walk reference.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [7:0]  memData;
  logic [15:0] pc;
  logic        pcEnable, pcLoad, memOutputEnable;
  logic [15:0] pcInAddr;
  logic        jumpValid, halt, instrValid, instrReady;
  logic [15:0] jumpTarget;
  logic [7:0]  opcode;
  logic [15:0] operand, instrAddr;
  logic [1:0]  instrLength;

  logic [7:0] mem [0:65535];

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [15:0] addr;
    logic [1:0]  len;
  } instr_t;

  instr_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int jmp_cyc = 0;

  instruction_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .memData(memData), .pc(pc),
    .pcEnable(pcEnable), .pcLoad(pcLoad), .pcInAddr(pcInAddr),
    .memOutputEnable(memOutputEnable), .jumpValid(jumpValid),
    .jumpTarget(jumpTarget), .halt(halt), .instrValid(instrValid),
    .instrReady(instrReady), .opcode(opcode), .operand(operand),
    .instrAddr(instrAddr), .instrLength(instrLength)
  );

  // clock / reset and environment (PC register, combinational memory)
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (reset)         pc <= 16'h0000;
    else if (pcLoad)   pc <= pcInAddr;
    else if (pcEnable) pc <= pc + 16'h0001;
  end
  assign memData = mem[pc];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference: instruction as it sits in memory at address a
  function automatic instr_t model(input logic [15:0] a);
    instr_t t;
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    t.op   = mem[a];
    t.addr = a;
    if (t.op < 8'h40)      t.len = 2'd1;
    else if (t.op < 8'h80) t.len = 2'd2;
    else                   t.len = 2'd3;
    t.opnd = {(t.len == 2'd3) ? mem[a2] : 8'h00, (t.len != 2'd1) ? mem[a1] : 8'h00};
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_instr();
    instr_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_instr", {16'h0, instrAddr}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("opcode", {24'h0, opcode}, {24'h0, e.op});
      check("operand", {16'h0, operand}, {16'h0, e.opnd});
      check("instrAddr", {16'h0, instrAddr}, {16'h0, e.addr});
      check("instrLength", {30'h0, instrLength}, {30'h0, e.len});
    end
  endtask

  // ends on the negedge of the first cycle showing instrValid
  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (instrValid) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    if (!found) check("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  task automatic take(input int exp_rel);
    bit found;
    wait_valid(found);
    if (found) begin
      if (exp_rel >= 0) check("valid_cycle", cyc - jmp_cyc, exp_rel);
      compare_instr();
      next_cycle();
    end
  endtask

  task automatic do_jump(input logic [15:0] t);
    jumpValid  = 1'b1;
    jumpTarget = t;
    @(negedge clk);
    jmp_cyc = cyc;
    next_cycle();
    jumpValid = 1'b0;
  endtask

  task automatic random_take();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      halt       = 1'($urandom_range(0, 1));
      instrReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (instrValid && instrReady) begin
        compare_instr();
        done = 1'b1;
      end
      next_cycle();
    end
    halt       = 1'b0;
    instrReady = 1'b1;
    if (!done) check("random_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    bit found;
    logic [15:0] t;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[16'h0010] = 8'h05; mem[16'h0011] = 8'h45; mem[16'h0012] = 8'h34;
    mem[16'h0013] = 8'h85; mem[16'h0014] = 8'h78; mem[16'h0015] = 8'h56;
    mem[16'h00A0] = 8'h41; mem[16'h00A1] = 8'h22;
    reset = 1'b1; jumpValid = 1'b0; jumpTarget = 16'h0; halt = 1'b0; instrReady = 1'b1;

    // reset: controls forced low, then reset values on the redirect cycle
    next_cycle();
    jumpValid = 1'b1; jumpTarget = 16'h1234;
    @(negedge clk);
    check("rst_pcLoad", {31'h0, pcLoad}, 32'h0);
    check("rst_pcEnable", {31'h0, pcEnable}, 32'h0);
    check("rst_memOE", {31'h0, memOutputEnable}, 32'h0);
    check("rst_pcInAddr", {16'h0, pcInAddr}, 32'h0);
    next_cycle();
    reset = 1'b0; jumpTarget = 16'h0010;
    @(negedge clk);
    jmp_cyc = cyc;
    check("init_instrValid", {31'h0, instrValid}, 32'h0);
    check("init_opcode", {24'h0, opcode}, 32'h0);
    check("init_operand", {16'h0, operand}, 32'h0);
    check("init_instrAddr", {16'h0, instrAddr}, 32'h0);
    check("init_instrLength", {30'h0, instrLength}, 32'h0);
    check("jmp_pcLoad", {31'h0, pcLoad}, 32'h1);
    check("jmp_pcInAddr", {16'h0, pcInAddr}, 32'h0010);
    check("jmp_pcEnable", {31'h0, pcEnable}, 32'h0);
    check("jmp_memOE", {31'h0, memOutputEnable}, 32'h0);
    next_cycle();
    jumpValid = 1'b0;
    exp_q.push_back(model(16'h0010));
    exp_q.push_back(model(16'h0011));
    exp_q.push_back(model(16'h0013));
    take(2);
    take(5);
    take(9);

    // decoder back-pressure in HOLD
    instrReady = 1'b0;
    exp_q.push_back(model(16'h0013));
    do_jump(16'h0013);
    wait_valid(found);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        next_cycle();
        @(negedge clk);
      end
      check("stall_valid", {31'h0, instrValid}, 32'h1);
      check("stall_opcode", {24'h0, opcode}, 32'h85);
      check("stall_operand", {16'h0, operand}, 32'h5678);
      check("stall_instrAddr", {16'h0, instrAddr}, 32'h0013);
      check("stall_pcEnable", {31'h0, pcEnable}, 32'h0);
      check("stall_pc", {16'h0, pc}, 32'h0016);
    end
    next_cycle();
    instrReady = 1'b1;
    take(-1);

    // redirect during FETCH_LO of the 2-byte instruction
    exp_q.push_back(model(16'h00A0));
    do_jump(16'h0011);
    next_cycle();
    jumpValid = 1'b1; jumpTarget = 16'h00A0;
    @(negedge clk);
    jmp_cyc = cyc;
    check("lo_jmp_pcLoad", {31'h0, pcLoad}, 32'h1);
    check("lo_jmp_pcInAddr", {16'h0, pcInAddr}, 32'h00A0);
    check("lo_jmp_pcEnable", {31'h0, pcEnable}, 32'h0);
    check("lo_jmp_valid", {31'h0, instrValid}, 32'h0);
    next_cycle();
    jumpValid = 1'b0;
    @(negedge clk);
    check("lo_jmp_pcLoad_drop", {31'h0, pcLoad}, 32'h0);
    check("lo_jmp_pc", {16'h0, pc}, 32'h00A0);
    next_cycle();
    take(3);

    // halt during FETCH_HI
    exp_q.push_back(model(16'h0013));
    do_jump(16'h0013);
    next_cycle();
    next_cycle();
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("halt_pcEnable", {31'h0, pcEnable}, 32'h0);
      check("halt_memOE", {31'h0, memOutputEnable}, 32'h0);
      check("halt_pc", {16'h0, pc}, 32'h0015);
      check("halt_valid", {31'h0, instrValid}, 32'h0);
      next_cycle();
    end
    halt = 1'b0;
    take(7);

    // PC wrap-around inside an instruction
    mem[16'hFFFF] = 8'h85; mem[16'h0000] = 8'hCD; mem[16'h0001] = 8'hAB;
    exp_q.push_back(model(16'hFFFF));
    do_jump(16'hFFFF);
    take(4);

    // random targets, random halt and decoder back-pressure
    for (int it = 0; it < 10; it++) begin
      t = 16'($urandom_range(0, 65535));
      for (int b = 0; b < 6; b++) mem[16'(t + 16'(b))] = 8'($urandom_range(0, 255));
      exp_q.push_back(model(t));
      exp_q.push_back(model(16'(t + 16'(model(t).len))));
      do_jump(t);
      random_take();
      random_take();
    end
    check("queue_empty", exp_q.size(), 0);

    // reset in FETCH_LO aborts the instruction; fetch restarts at 0
    mem[16'h0000] = 8'h07;
    do_jump(16'h0013);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_pcEnable", {31'h0, pcEnable}, 32'h0);
    check("midrst_memOE", {31'h0, memOutputEnable}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("midrst_valid", {31'h0, instrValid}, 32'h0);
    check("midrst_pcLoad", {31'h0, pcLoad}, 32'h0);
    check("midrst_pcEnable2", {31'h0, pcEnable}, 32'h0);
    check("midrst_opcode", {24'h0, opcode}, 32'h0);
    next_cycle();
    reset = 1'b0;
    exp_q.push_back(model(16'h0000));
    @(negedge clk);
    check("post_rst_pc", {16'h0, pc}, 32'h0);
    check("post_rst_pcEnable", {31'h0, pcEnable}, 32'h1);
    next_cycle();
    take(-1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
